// File: rtl/tempsens_pkg.sv
// Shared types and constants for the temperature-sensor UART reader.
// Holds the FSM encodings, reply byte positions and the bit-period helper.
package tempsens_pkg;

   typedef enum logic [2:0] {IDLE, SEND, WAIT0, WAIT1, WAIT2} state_t;
   typedef enum logic [1:0] {HUNT, START, DATA, STOP} rx_state_t;

   localparam int BYTE0      = 0;
   localparam int BYTE1      = 1;
   localparam int BYTE2      = 2;
   localparam int FRAME_BITS = 10;

   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-start glitch check, LSB-first shifter.
// Emits one-cycle valid on a good stop bit, one-cycle ferr on a low stop bit.
module uart_rx_byte
   import tempsens_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       ferr
);

   localparam int CW = $clog2(DIV);

   logic            sync1_reg, sync2_reg, prev_reg;
   rx_state_t       rx_state_reg, rx_state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2:0]      bit_reg, bit_next;
   logic [7:0]      shift_reg, shift_next;
   logic            valid_reg, valid_next;
   logic            ferr_reg, ferr_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg    <= 1'b1;
         sync2_reg    <= 1'b1;
         prev_reg     <= 1'b1;
         rx_state_reg <= HUNT;
         cnt_reg      <= '0;
         bit_reg      <= '0;
         shift_reg    <= '0;
         valid_reg    <= 1'b0;
         ferr_reg     <= 1'b0;
      end else begin
         sync1_reg    <= rx;
         sync2_reg    <= sync1_reg;
         prev_reg     <= sync2_reg;
         rx_state_reg <= rx_state_next;
         cnt_reg      <= cnt_next;
         bit_reg      <= bit_next;
         shift_reg    <= shift_next;
         valid_reg    <= valid_next;
         ferr_reg     <= ferr_next;
      end
   end

   // The edge is seen one cycle after it reaches sync2, so START begins its count at 1.
   always_comb begin
      rx_state_next = rx_state_reg;
      cnt_next      = cnt_reg + 1'b1;
      bit_next      = bit_reg;
      shift_next    = shift_reg;
      valid_next    = 1'b0;
      ferr_next     = 1'b0;
      case (rx_state_reg)
         HUNT: begin
            cnt_next = CW'(1);
            if (prev_reg && !sync2_reg) rx_state_next = START;
         end
         START: begin
            if (cnt_reg == CW'(DIV/2 - 1)) begin
               cnt_next      = '0;
               bit_next      = '0;
               rx_state_next = sync2_reg ? HUNT : DATA;
            end
         end
         DATA: begin
            if (cnt_reg == CW'(DIV - 1)) begin
               cnt_next   = '0;
               shift_next = {sync2_reg, shift_reg[7:1]};
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) rx_state_next = STOP;
            end
         end
         STOP: begin
            if (cnt_reg == CW'(DIV - 1)) begin
               cnt_next      = '0;
               valid_next    = sync2_reg;
               ferr_next     = !sync2_reg;
               rx_state_next = HUNT;
            end
         end
         default: rx_state_next = HUNT;
      endcase
   end

   assign data  = shift_reg;
   assign valid = valid_reg;
   assign ferr  = ferr_reg;

endmodule

// File: rtl/tempsens_reader.sv
// Host-side initiator: sends one command byte, gathers a 3-byte LSB-first reply,
// and publishes the 24-bit count with done / timeout / frame_err strobes.
module tempsens_reader
   import tempsens_pkg::*;
#(
   parameter int          CLK_FREQ  = 10000,
   parameter int          BAUD      = 1000,
   parameter logic [7:0]  START_CMD = 8'h53,
   parameter logic [15:0] TIMEOUT   = 16'd65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        frame_err,
   output logic [23:0] result
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam int CW  = $clog2(DIV);

   state_t          state_reg, state_next;
   logic            tx_reg, tx_next;
   logic [8:0]      tx_shift_reg, tx_shift_next;
   logic [CW-1:0]   tx_cnt_reg, tx_cnt_next;
   logic [3:0]      tx_bit_reg, tx_bit_next;
   logic [15:0]     to_cnt_reg, to_cnt_next;
   logic [1:0][7:0] reply_reg, reply_next;
   logic [23:0]     result_reg, result_next;
   logic            done_reg, done_next;
   logic            timeout_reg, timeout_next;
   logic            ferr_reg, ferr_next;

   logic [7:0]      rx_data;
   logic            rx_valid, rx_ferr;

   uart_rx_byte #(.DIV(DIV)) u_rx (
      .clk   (clk),
      .reset (reset),
      .rx    (uart_rx),
      .data  (rx_data),
      .valid (rx_valid),
      .ferr  (rx_ferr)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         tx_reg       <= 1'b1;
         tx_shift_reg <= '1;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         to_cnt_reg   <= '0;
         reply_reg    <= '0;
         result_reg   <= '0;
         done_reg     <= 1'b0;
         timeout_reg  <= 1'b0;
         ferr_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tx_reg       <= tx_next;
         tx_shift_reg <= tx_shift_next;
         tx_cnt_reg   <= tx_cnt_next;
         tx_bit_reg   <= tx_bit_next;
         to_cnt_reg   <= to_cnt_next;
         reply_reg    <= reply_next;
         result_reg   <= result_next;
         done_reg     <= done_next;
         timeout_reg  <= timeout_next;
         ferr_reg     <= ferr_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      tx_next       = tx_reg;
      tx_shift_next = tx_shift_reg;
      tx_cnt_next   = tx_cnt_reg;
      tx_bit_next   = tx_bit_reg;
      to_cnt_next   = '0;
      reply_next    = reply_reg;
      result_next   = result_reg;
      done_next     = 1'b0;
      timeout_next  = 1'b0;
      ferr_next     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next    = SEND;
               tx_next       = 1'b0;
               tx_shift_next = {1'b1, START_CMD};
               tx_cnt_next   = '0;
               tx_bit_next   = '0;
            end
         end
         SEND: begin
            // Shifter carries the stop bit behind the data, so bit 9 is the final idle-high period.
            if (tx_cnt_reg == CW'(DIV - 1)) begin
               tx_cnt_next = '0;
               if (tx_bit_reg == 4'(FRAME_BITS - 1)) begin
                  state_next = WAIT0;
                  tx_next    = 1'b1;
               end else begin
                  tx_next       = tx_shift_reg[0];
                  tx_shift_next = {1'b1, tx_shift_reg[8:1]};
                  tx_bit_next   = tx_bit_reg + 4'd1;
               end
            end else begin
               tx_cnt_next = tx_cnt_reg + 1'b1;
            end
         end
         WAIT0, WAIT1, WAIT2: begin
            to_cnt_next = to_cnt_reg + 16'd1;
            if (rx_valid) begin
               to_cnt_next = '0;
               if (state_reg == WAIT0) begin
                  reply_next[BYTE0] = rx_data;
                  state_next        = WAIT1;
               end else if (state_reg == WAIT1) begin
                  reply_next[BYTE1] = rx_data;
                  state_next        = WAIT2;
               end else begin
                  result_next[BYTE2*8 +: 8] = rx_data;
                  result_next[BYTE1*8 +: 8] = reply_reg[BYTE1];
                  result_next[BYTE0*8 +: 8] = reply_reg[BYTE0];
                  done_next                 = 1'b1;
                  state_next                = IDLE;
               end
            end else if (rx_ferr) begin
               reply_next = '0;
               ferr_next  = 1'b1;
               state_next = IDLE;
            end else if (to_cnt_reg == TIMEOUT - 16'd1) begin
               timeout_next = 1'b1;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign uart_tx   = tx_reg;
   assign busy      = (state_reg != IDLE);
   assign done      = done_reg;
   assign timeout   = timeout_reg;
   assign frame_err = ferr_reg;
   assign result    = result_reg;

endmodule

// File: tb/tb_tempsens_reader.sv
// Directed bench for tempsens_reader: command waveform, reply assembly, timeout,
// frame error, glitch/stray rejection, mid-send reset and back-to-back starts.
module tb_tempsens_reader;

   localparam int         DIV     = 10;
   localparam int         TIMEOUT = 65535;
   localparam logic [7:0] CMD     = 8'h53;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        uart_rx = 1'b1;
   logic        uart_tx, busy, done, timeout, frame_err;
   logic [23:0] result;

   int total = 0;
   int passed = 0;
   int cyc = 0;

   int done_cnt = 0, done_cyc = 0, to_cnt = 0, to_cyc = 0;
   int ferr_cnt = 0, ferr_cyc = 0, excl_err = 0, busy_rise_cyc = 0;
   logic done_busy = 1'b1;
   logic busy_prev = 1'b0;

   tempsens_reader #(
      .CLK_FREQ  (10000),
      .BAUD      (1000),
      .START_CMD (CMD),
      .TIMEOUT   (16'(TIMEOUT))
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .uart_rx   (uart_rx),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .done      (done),
      .timeout   (timeout),
      .frame_err (frame_err),
      .result    (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt  <= done_cnt + 1;
         done_cyc  <= cyc;
         done_busy <= busy;
      end
      if (timeout === 1'b1) begin
         to_cnt <= to_cnt + 1;
         to_cyc <= cyc;
      end
      if (frame_err === 1'b1) begin
         ferr_cnt <= ferr_cnt + 1;
         ferr_cyc <= cyc;
      end
      if ((32'(done) + 32'(timeout) + 32'(frame_err)) > 32'd1) excl_err <= excl_err + 1;
      if (busy === 1'b1 && busy_prev === 1'b0) busy_rise_cyc <= cyc;
      busy_prev <= busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic goto_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int p);
      p = cyc;
      uart_rx = 1'b0;
      tick(DIV);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(DIV);
      end
      uart_rx = stop_bit;
      tick(DIV);
      uart_rx = 1'b1;
      tick(2);
   endtask

   task automatic wait_busy_rise(input string tag, output int e);
      bit found;
      found = 1'b0;
      e = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            found = 1'b1;
            e = cyc;
         end
      end
      check({tag, " busy_rise"}, 32'(found), 32'd1);
   endtask

   // Starts at the negedge of the first SEND cycle; compares every cycle of the frame.
   task automatic check_tx(input string tag, input int ncyc);
      logic [9:0] frame;
      int mism;
      frame = {1'b1, CMD, 1'b0};
      mism = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) @(negedge clk);
         if (uart_tx !== frame[c / DIV]) mism++;
      end
      check({tag, " tx_wave_mismatches"}, 32'(mism), 32'd0);
   endtask

   initial begin
      int e, e2, p, d0, t0, f0, dc1;

      tick(3);
      check("rst uart_tx", 32'(uart_tx), 32'd1);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst timeout", 32'(timeout), 32'd0);
      check("rst frame_err", 32'(frame_err), 32'd0);
      check("rst result", 32'(result), 32'd0);
      reset = 1'b1;
      tick(3);

      // nominal transaction
      start = 1'b1;
      wait_busy_rise("nom", e);
      start = 1'b0;
      check_tx("nom", 100);
      goto_cyc(e + 100);
      d0 = done_cnt;
      send_byte(8'h34, 1'b1, p);
      send_byte(8'h12, 1'b1, p);
      send_byte(8'hAB, 1'b1, p);
      check("nom result", 32'(result), 32'h00AB1234);
      check("nom done_count", 32'(done_cnt - d0), 32'd1);
      check("nom done_latency", 32'(done_cyc - p), 32'd98);
      check("nom busy_at_done", 32'(done_busy), 32'd0);
      $display("txn nominal: result=%06h", result);

      // timeout in WAIT2
      start = 1'b1;
      wait_busy_rise("to", e);
      start = 1'b0;
      goto_cyc(e + 100);
      d0 = done_cnt;
      t0 = to_cnt;
      send_byte(8'h01, 1'b1, p);
      send_byte(8'h02, 1'b1, p);
      for (int i = 0; i < 70000 && to_cnt == t0; i++) @(negedge clk);
      @(negedge clk);
      check("to count", 32'(to_cnt - t0), 32'd1);
      check("to latency", 32'(to_cyc - p), 32'(98 + TIMEOUT));
      check("to result_kept", 32'(result), 32'h00AB1234);
      check("to no_done", 32'(done_cnt - d0), 32'd0);
      check("to busy", 32'(busy), 32'd0);
      $display("txn timeout: cycles_after_byte1_start=%0d", to_cyc - p);
      tick(2);

      // frame error in WAIT1
      start = 1'b1;
      wait_busy_rise("ferr", e);
      start = 1'b0;
      goto_cyc(e + 100);
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_byte(8'h10, 1'b1, p);
      send_byte(8'h55, 1'b0, p);
      check("ferr count", 32'(ferr_cnt - f0), 32'd1);
      check("ferr latency", 32'(ferr_cyc - p), 32'd98);
      check("ferr result_kept", 32'(result), 32'h00AB1234);
      check("ferr no_done", 32'(done_cnt - d0), 32'd0);
      check("ferr busy", 32'(busy), 32'd0);
      $display("txn frame_err: result=%06h", result);

      // stray byte while idle, then glitch during WAIT0
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_byte(8'h77, 1'b1, p);
      check("stray no_done", 32'(done_cnt - d0), 32'd0);
      check("stray no_ferr", 32'(ferr_cnt - f0), 32'd0);
      check("stray busy", 32'(busy), 32'd0);
      start = 1'b1;
      wait_busy_rise("glitch", e);
      start = 1'b0;
      goto_cyc(e + 100);
      uart_rx = 1'b0;
      tick(3);
      uart_rx = 1'b1;
      tick(20);
      send_byte(8'h9A, 1'b1, p);
      send_byte(8'hBC, 1'b1, p);
      send_byte(8'hDE, 1'b1, p);
      check("glitch result", 32'(result), 32'h00DEBC9A);
      check("glitch done_count", 32'(done_cnt - d0), 32'd1);
      $display("txn glitch: result=%06h", result);

      // reset 40 cycles into SEND
      start = 1'b1;
      wait_busy_rise("rst", e);
      start = 1'b0;
      check_tx("rst", 40);
      goto_cyc(e + 40);
      check("midsend tx_before", 32'(uart_tx), 32'd0);
      check("midsend busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      check("midsend uart_tx", 32'(uart_tx), 32'd1);
      check("midsend busy", 32'(busy), 32'd0);
      check("midsend done", 32'(done), 32'd0);
      check("midsend timeout", 32'(timeout), 32'd0);
      check("midsend frame_err", 32'(frame_err), 32'd0);
      check("midsend result", 32'(result), 32'd0);
      tick(2);
      reset = 1'b1;
      tick(2);
      start = 1'b1;
      wait_busy_rise("post_rst", e);
      start = 1'b0;
      check_tx("post_rst", 100);
      goto_cyc(e + 100);
      d0 = done_cnt;
      send_byte(8'h11, 1'b1, p);
      send_byte(8'h22, 1'b1, p);
      send_byte(8'h33, 1'b1, p);
      check("post_rst result", 32'(result), 32'h00332211);
      check("post_rst done_count", 32'(done_cnt - d0), 32'd1);
      $display("txn reset_recovery: result=%06h", result);

      // start held high across two transactions
      start = 1'b1;
      wait_busy_rise("held1", e);
      goto_cyc(e + 100);
      d0 = done_cnt;
      send_byte(8'hC1, 1'b1, p);
      send_byte(8'hC2, 1'b1, p);
      send_byte(8'hC3, 1'b1, p);
      check("held1 result", 32'(result), 32'h00C3C2C1);
      dc1 = done_cyc;
      e2 = busy_rise_cyc;
      check("held2 restart_gap", 32'(e2 - dc1), 32'd1);
      start = 1'b0;
      $display("txn held1: result=%06h", result);
      goto_cyc(e2 + 100);
      send_byte(8'hD1, 1'b1, p);
      send_byte(8'hD2, 1'b1, p);
      send_byte(8'hD3, 1'b1, p);
      check("held2 result", 32'(result), 32'h00D3D2D1);
      check("held done_count", 32'(done_cnt - d0), 32'd2);
      tick(30);
      check("held no_third", 32'(busy), 32'd0);
      $display("txn held2: result=%06h", result);

      check("strobe exclusivity", 32'(excl_err), 32'd0);
      check("total timeouts", 32'(to_cnt), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
